// File: rtl/mmr_pkg.sv
// Shared constants and state types for the MMR register-file slave.
package mmr_pkg;
  localparam int DATA_W = 32;
  localparam int ID_W   = 12;
  localparam int WIN_W  = 12;  // 4 KB decode window, byte address bits

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic       {R_IDLE, R_DATA} rd_state_t;
endpackage

// File: rtl/mmr_if.sv
// AXI3 GP-port bundle between the PS7 master and the PL register slave.
interface mmr_if #(parameter int ID_W = mmr_pkg::ID_W);
  import mmr_pkg::*;

  logic [31:0]         awaddr;
  logic [3:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic [ID_W-1:0]     awid;
  logic                awvalid;
  logic                awready;
  logic [1:0]          awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic [3:0]          awqos;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic [ID_W-1:0]     wid;
  logic                wvalid;
  logic                wready;

  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  logic [31:0]         araddr;
  logic [3:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic [ID_W-1:0]     arid;
  logic                arvalid;
  logic                arready;
  logic [1:0]          arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic [3:0]          arqos;

  logic [DATA_W-1:0]   rdata;
  logic [ID_W-1:0]     rid;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awlen, awsize, awburst, awid, awvalid, awlock, awcache, awprot, awqos,
    input  awready,
    output wdata, wstrb, wlast, wid, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output araddr, arlen, arsize, arburst, arid, arvalid, arlock, arcache, arprot, arqos,
    input  arready,
    input  rdata, rid, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awid, awvalid, awlock, awcache, awprot, awqos,
    output awready,
    input  wdata, wstrb, wlast, wid, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  araddr, arlen, arsize, arburst, arid, arvalid, arlock, arcache, arprot, arqos,
    output arready,
    output rdata, rid, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/mmr_addr_gen_m.sv
// Beat address advance and register-index range check for one AXI channel.
module mmr_addr_gen_m
  import mmr_pkg::*;
#(
  parameter int REG_COUNT = 16
) (
  input  logic [WIN_W-1:0] addr,
  input  logic [1:0]       burst,
  output logic [WIN_W-1:0] next_addr,
  output logic [WIN_W-3:0] idx,
  output logic             oor
);
  localparam int CW = WIN_W - 1;  // one extra bit so REG_COUNT=1024 fits
  localparam logic [CW-1:0] RC = CW'(REG_COUNT);

  // WRAP advances like INCR; only FIXED holds the address
  assign next_addr = (burst == BURST_FIXED) ? addr : addr + WIN_W'(4);
  assign idx       = addr[WIN_W-1:2];
  assign oor       = {1'b0, idx} >= RC;
endmodule

// File: rtl/mmr_slave_m.sv
// AXI3 slave register file: independent read/write FSMs over REG_COUNT 32-bit registers.
module mmr_slave_m #(
  parameter int ID_W      = mmr_pkg::ID_W,
  parameter int REG_COUNT = 16
) (
  input  logic                                FCLK0,
  input  logic                                FCLK0_RST_N,
  mmr_if.slave                                MMR,
  output logic [REG_COUNT*mmr_pkg::DATA_W-1:0] regs_o,
  output logic [REG_COUNT-1:0]                wr_pulse_o
);
  import mmr_pkg::*;

  localparam int SW  = DATA_W / 8;
  localparam int IXW = WIN_W - 2;

  wr_state_t w_st, w_nxt;
  rd_state_t r_st, r_nxt;

  logic awready_q, wready_q, bvalid_q, awready_d, wready_d, bvalid_d;
  logic arready_q, rvalid_q, arready_d, rvalid_d;

  logic [WIN_W-1:0] waddr_q, w_next;
  logic [1:0]       wburst_q;
  logic [ID_W-1:0]  bid_q;
  logic [1:0]       bresp_q;
  logic             werr_q;
  logic [IXW-1:0]   w_idx;
  logic             w_oor;

  logic [WIN_W-1:0]  raddr_q, r_next, r_gen_addr;
  logic [1:0]        rburst_q, r_gen_burst;
  logic [3:0]        rlen_q, rcnt_q;
  logic [ID_W-1:0]   rid_q;
  logic [DATA_W-1:0] rdata_q, rd_word;
  logic [1:0]        rresp_q;
  logic              rlast_q;
  logic [IXW-1:0]    r_idx;
  logic              r_oor;

  logic [REG_COUNT-1:0][DATA_W-1:0] regs_q;
  logic [REG_COUNT-1:0]             pulse_q;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, w_we;
  assign aw_hs = MMR.awvalid & awready_q;
  assign w_hs  = MMR.wvalid  & wready_q;
  assign b_hs  = bvalid_q    & MMR.bready;
  assign ar_hs = MMR.arvalid & arready_q;
  assign r_hs  = rvalid_q    & MMR.rready;
  assign w_we  = w_hs & ~w_oor;

  // size, len on writes, wid and sideband qualifiers carry no meaning here
  logic unused_in;
  assign unused_in = ^{MMR.awaddr[31:WIN_W], MMR.araddr[31:WIN_W], MMR.awlen, MMR.awsize,
                       MMR.arsize, MMR.wid, MMR.awlock, MMR.awcache, MMR.awprot, MMR.awqos,
                       MMR.arlock, MMR.arcache, MMR.arprot, MMR.arqos};

  mmr_addr_gen_m #(.REG_COUNT(REG_COUNT)) u_wgen (
    .addr(waddr_q), .burst(wburst_q), .next_addr(w_next), .idx(w_idx), .oor(w_oor)
  );

  // in idle the read decode looks at the incoming AR so beat 0 loads on the handshake
  assign r_gen_addr  = (r_st == R_IDLE) ? MMR.araddr[WIN_W-1:0] : raddr_q;
  assign r_gen_burst = (r_st == R_IDLE) ? MMR.arburst : rburst_q;

  mmr_addr_gen_m #(.REG_COUNT(REG_COUNT)) u_rgen (
    .addr(r_gen_addr), .burst(r_gen_burst), .next_addr(r_next), .idx(r_idx), .oor(r_oor)
  );

  // ---------------- write FSM ----------------
  // write state and registered channel handshakes (all low while in reset)
  always_ff @(posedge FCLK0 or negedge FCLK0_RST_N) begin
    if (!FCLK0_RST_N) begin
      w_st      <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      w_st      <= w_nxt;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
    end
  end

  // write next-state
  always_comb begin
    w_nxt = w_st;
    case (w_st)
      W_IDLE:  if (aw_hs) w_nxt = W_DATA;
      W_DATA:  if (w_hs && MMR.wlast) w_nxt = W_RESP;
      W_RESP:  if (b_hs) w_nxt = W_IDLE;
      default: w_nxt = W_IDLE;
    endcase
  end

  // write handshake outputs follow the state being entered
  always_comb begin
    awready_d = (w_nxt == W_IDLE);
    wready_d  = (w_nxt == W_DATA);
    bvalid_d  = (w_nxt == W_RESP);
  end

  // write address tracking, sticky error and B response capture
  always_ff @(posedge FCLK0 or negedge FCLK0_RST_N) begin
    if (!FCLK0_RST_N) begin
      waddr_q  <= '0;
      wburst_q <= BURST_FIXED;
      bid_q    <= '0;
      bresp_q  <= RESP_OKAY;
      werr_q   <= 1'b0;
    end else if (aw_hs) begin
      waddr_q  <= MMR.awaddr[WIN_W-1:0];
      wburst_q <= MMR.awburst;
      bid_q    <= MMR.awid;
      werr_q   <= 1'b0;
    end else if (w_hs) begin
      waddr_q <= w_next;
      if (w_oor) werr_q <= 1'b1;
      if (MMR.wlast) bresp_q <= (werr_q || w_oor) ? RESP_SLVERR : RESP_OKAY;
    end else if (b_hs) begin
      werr_q <= 1'b0;
    end
  end

  // register bank: byte-lane merge on in-range beats, pulse one cycle later
  always_ff @(posedge FCLK0 or negedge FCLK0_RST_N) begin
    if (!FCLK0_RST_N) begin
      regs_q  <= '0;
      pulse_q <= '0;
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        pulse_q[i] <= w_we && (w_idx == IXW'(i));
        if (w_we && (w_idx == IXW'(i))) begin
          for (int b = 0; b < SW; b++)
            if (MMR.wstrb[b]) regs_q[i][b*8 +: 8] <= MMR.wdata[b*8 +: 8];
        end
      end
    end
  end

  // ---------------- read FSM ----------------
  // read state and registered handshakes
  always_ff @(posedge FCLK0 or negedge FCLK0_RST_N) begin
    if (!FCLK0_RST_N) begin
      r_st      <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      r_st      <= r_nxt;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
    end
  end

  // read next-state
  always_comb begin
    r_nxt = r_st;
    case (r_st)
      R_IDLE:  if (ar_hs) r_nxt = R_DATA;
      R_DATA:  if (r_hs && rlast_q) r_nxt = R_IDLE;
      default: r_nxt = R_IDLE;
    endcase
  end

  // read handshake outputs follow the state being entered
  always_comb begin
    arready_d = (r_nxt == R_IDLE);
    rvalid_d  = (r_nxt == R_DATA);
  end

  // register select for the beat being loaded
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < REG_COUNT; i++)
      if (r_idx == IXW'(i)) rd_word = regs_q[i];
  end

  // read beat pipeline: raddr_q points at the next beat to load; R outputs hold while stalled
  always_ff @(posedge FCLK0 or negedge FCLK0_RST_N) begin
    if (!FCLK0_RST_N) begin
      raddr_q  <= '0;
      rburst_q <= BURST_FIXED;
      rlen_q   <= '0;
      rcnt_q   <= '0;
      rid_q    <= '0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      rlast_q  <= 1'b0;
    end else if (ar_hs) begin
      raddr_q  <= r_next;
      rburst_q <= MMR.arburst;
      rlen_q   <= MMR.arlen;
      rcnt_q   <= '0;
      rid_q    <= MMR.arid;
      rdata_q  <= r_oor ? '0 : rd_word;
      rresp_q  <= r_oor ? RESP_SLVERR : RESP_OKAY;
      rlast_q  <= (MMR.arlen == 4'd0);
    end else if (r_hs && !rlast_q) begin
      raddr_q <= r_next;
      rcnt_q  <= rcnt_q + 4'd1;
      rdata_q <= r_oor ? '0 : rd_word;
      rresp_q <= r_oor ? RESP_SLVERR : RESP_OKAY;
      rlast_q <= ((rcnt_q + 4'd1) == rlen_q);
    end
  end

  assign MMR.awready = awready_q;
  assign MMR.wready  = wready_q;
  assign MMR.bvalid  = bvalid_q;
  assign MMR.bid     = bid_q;
  assign MMR.bresp   = bresp_q;
  assign MMR.arready = arready_q;
  assign MMR.rvalid  = rvalid_q;
  assign MMR.rdata   = rdata_q;
  assign MMR.rid     = rid_q;
  assign MMR.rresp   = rresp_q;
  assign MMR.rlast   = rlast_q;

  assign regs_o     = regs_q;
  assign wr_pulse_o = pulse_q;
endmodule

// File: doc/mmr_slave_m.md
# mmr_slave_m

AXI3 slave register file on the PL side of the PS7 GP master port (MMR_*). It terminates PS-initiated read and write transactions, including FIXED and INCR bursts, into a bank of 32-bit control registers. It exposes their contents and per-register write strobes to PL logic. It runs in the FCLK0 domain and connects port-for-port to the MMR_* pins of ps7_hw_wrapper.

## Interface
- DATA_W, `DATA_WIDTH (32): data width; localparam, not overridable.
- ID_W, 12: AXI ID width (PS7 GP master).
- REG_COUNT, 16: number of RW registers, 1..1024.
- FCLK0  in  1  clock.
- FCLK0_RST_N  in  1  asynchronous, active-low reset.
- MMR_aw{addr,len,size,burst,id,valid}  in  32/4/3/2/ID_W/1  write address channel.
- MMR_awready  out  1
- MMR_w{data,strb,last,id,valid}  in  DATA_W/DATA_W/8/1/ID_W/1  write data channel.
- MMR_wready  out  1
- MMR_b{id,resp,valid}  out  ID_W/2/1;  MMR_bready  in  1
- MMR_ar{addr,len,size,burst,id,valid}  in  as AW;  MMR_arready  out  1
- MMR_r{data,id,resp,last,valid}  out  DATA_W/ID_W/2/1/1;  MMR_rready  in  1
- MMR_{aw,ar}{lock,cache,prot,qos}  in  2/4/3/4  accepted and ignored.
- regs_o  out  REG_COUNT*DATA_W  register contents; reg i is at bits [i*32 +: 32].
- wr_pulse_o  out  REG_COUNT  one-cycle pulse on the cycle after a beat writes reg i.

## Operation
- Decode: offset = addr[11:0] (4 KB window; the interconnect decodes the base address). idx = offset[11:2]. idx >= REG_COUNT is out of range.
- Write FSM states W_IDLE, W_DATA, W_RESP.
  - W_IDLE: awready=1. On AW handshake, latch addr, id and burst; go to W_DATA.
  - W_DATA: wready=1. Each beat writes the byte lanes selected by wstrb to reg[idx].
    - Out-of-range beats are dropped and set the sticky error flag.
    - After each beat, addr += 4 unless burst==FIXED. WRAP is treated as INCR.
    - The beat with wlast=1 moves to W_RESP. wid and len are not checked.
  - W_RESP: bvalid=1, bid = latched id, bresp = SLVERR (2'b10) if the error flag is set, else OKAY (2'b00). On bready, go to W_IDLE and clear the flag.
- Read FSM states R_IDLE, R_DATA.
  - R_IDLE: arready=1. On AR handshake, latch addr, len, id and burst; load rdata for beat 0; go to R_DATA.
  - R_DATA: rvalid=1. rresp = SLVERR with rdata = 0 for out-of-range beats. rlast=1 when beat count == len.
  - On each handshake, advance the address (same rule as writes) and reload rdata. The handshake that has rlast=1 goes to R_IDLE.
- Read and write FSMs run independently and concurrently.
- Read/write collision on one register in the same cycle: read captures the pre-write value. The write then commits.
- awsize/arsize below 2 are ignored; narrow writes rely on wstrb alone.

## Timing
- Reset values:
  - all registers 0;
  - awready, wready, arready, bvalid, rvalid, rlast, wr_pulse_o all 0;
  - bresp, rresp, bid, rid, rdata all 0.
- FSMs enter their idle states. awready and arready go to 1 on the first clock edge after reset deassertion.
- Write path:
  - AW handshake in cycle N gives wready=1 from N+1.
  - wlast beat in cycle M gives bvalid=1 in M+1; the register value is visible on regs_o in M+1.
  - Next awready is 1 in the cycle after the B handshake.
- Read path:
  - AR handshake in cycle N gives rvalid=1 with beat 0 in N+1.
  - With rready held high, each subsequent beat follows one cycle later, so a len=L burst finishes in N+1+L.
- Backpressure: while rvalid=1 and rready=0, rdata, rresp, rid and rlast are held stable. bvalid holds until bready.
- Reset asserted mid-transaction aborts the transaction and returns all outputs to reset values; no response is issued for the aborted transaction.

## Structure
- Package mmr_pkg holds:
  - resp codes OKAY/SLVERR;
  - burst codes FIXED/INCR/WRAP;
  - enums wr_state_t {W_IDLE,W_DATA,W_RESP} and rd_state_t {R_IDLE,R_DATA};
  - ID_W and the 12-bit window width.
- Sub-module mmr_addr_gen_m: next-address and range-check logic, instantiated once per channel. Inputs are addr, burst and REG_COUNT; outputs are next_addr, idx and oor.

## Test plan
- Single write of 0x12345678 to offset 0x00C with wstrb 4'b0011, reg 3 pre-loaded with 0xAAAAAAAA -> reg 3 = 0xAAAA5678; bresp=00; wr_pulse_o[3] pulses once.
- INCR write burst, len=3, at 0x010 with data 1,2,3,4, then INCR read burst len=3 at 0x010 -> regs 4..7 = 1..4; reads return 1,2,3,4; rlast=1 on beat 3 only; rid echoes arid=0x5A3.
- Write to 0x050 (idx 20, REG_COUNT=16) -> bresp=10, no register changes, no pulse; read of 0x050 -> rresp=10, rdata=0.
- FIXED read burst len=2 at reg 2 with rready low for 3 cycles on beat 1 -> rdata is reg 2 on every beat and stays stable while stalled; 3 handshakes total.
- Same-cycle write of 0xFFFFFFFF to reg 1 (old value 0x11) and read AR of reg 1 -> rdata=0x11; a following read returns 0xFFFFFFFF.
- FCLK0_RST_N asserted mid W_DATA of a len=7 burst -> all registers 0, no bvalid; awready=1 on the first edge after release.
